// File: rtl/pma_region_classifier.sv
// pma_region_classifier
// Two-stage physical-attribute lookup for the memory-request path.
// S1 registers the incoming address and tag. The region compares run between S1 and S2.
// S2 holds the reduced flags and drives the response outputs directly.
// The region tables default to the standard core memory map:
//   - debug region: 0x0 + 4 KiB
//   - boot ROM: 0x1_0000 + 64 KiB
//   - DRAM: 0x8000_0000 + 1 GiB
// Only the first NR_*_RULES entries of each table are evaluated.
module pma_region_classifier #(
    parameter int unsigned                 PLEN              = 56,
    parameter int unsigned                 TAG_W             = 4,
    parameter int unsigned                 MAX_RULES         = 4,
    parameter bit                          NON_IDEM_EN       = 1'b0,
    parameter int unsigned                 NR_NON_IDEM_RULES = 2,
    parameter logic [MAX_RULES-1:0][63:0]  NON_IDEM_BASE     = '0,
    parameter logic [MAX_RULES-1:0][63:0]  NON_IDEM_LEN      = '0,
    parameter int unsigned                 NR_EXEC_RULES     = 3,
    parameter logic [MAX_RULES-1:0][63:0]  EXEC_BASE         = {64'h0, 64'h8000_0000, 64'h1_0000, 64'h0},
    parameter logic [MAX_RULES-1:0][63:0]  EXEC_LEN          = {64'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
    parameter int unsigned                 NR_CACHED_RULES   = 1,
    parameter logic [MAX_RULES-1:0][63:0]  CACHED_BASE       = {64'h0, 64'h0, 64'h0, 64'h8000_0000},
    parameter logic [MAX_RULES-1:0][63:0]  CACHED_LEN        = {64'h0, 64'h0, 64'h0, 64'h4000_0000}
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [PLEN-1:0]  req_paddr_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_cached_o,
    output logic             rsp_exec_o,
    output logic             rsp_nonidem_o,
    output logic [15:0]      unmapped_cnt_o
);

    // The subtraction wraps modulo 2^64. That makes a region ending at the top of
    // the address space behave correctly. Empty rules are excluded explicitly.
    function automatic logic rule_hit(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] len);
        return (len != 64'd0) && ((addr - base) < len);
    endfunction

    logic             r_s1_valid;
    logic [PLEN-1:0]  r_s1_paddr;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_cached;
    logic             r_s2_exec;
    logic             r_s2_nonidem;

    logic [15:0]      r_unmapped_cnt;

    logic [63:0]      w_paddr64;
    logic             w_cached_hit;
    logic             w_exec_hit;
    logic             w_nonidem_hit;
    logic             w_s2_can_load;
    logic             w_s1_can_load;
    logic             w_unmapped_fire;

    assign w_paddr64       = 64'(r_s1_paddr);
    assign w_s2_can_load   = !r_s2_valid || rsp_ready_i;
    assign w_s1_can_load   = !r_s1_valid || w_s2_can_load;
    assign req_ready_o     = w_s1_can_load && !flush_i;
    assign w_unmapped_fire = r_s2_valid && rsp_ready_i && !r_s2_cached && !r_s2_exec;

    // Region compare between S1 and S2: each table reduces to one OR over its active rules.
    always_comb begin
        w_cached_hit  = 1'b0;
        w_exec_hit    = 1'b0;
        w_nonidem_hit = 1'b0;
        for (int i = 0; i < int'(MAX_RULES); i++) begin
            if (i < int'(NR_CACHED_RULES) && rule_hit(w_paddr64, CACHED_BASE[i], CACHED_LEN[i]))
                w_cached_hit = 1'b1;
            if (i < int'(NR_EXEC_RULES) && rule_hit(w_paddr64, EXEC_BASE[i], EXEC_LEN[i]))
                w_exec_hit = 1'b1;
            if (i < int'(NR_NON_IDEM_RULES) && rule_hit(w_paddr64, NON_IDEM_BASE[i], NON_IDEM_LEN[i]))
                w_nonidem_hit = 1'b1;
        end
        if (!NON_IDEM_EN)
            w_nonidem_hit = 1'b0;
    end

    // S1: capture an accepted request. A flush empties the stage without accepting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_paddr <= '0;
            r_s1_tag   <= '0;
        end else if (flush_i) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_can_load) begin
            r_s1_valid <= req_valid_i;
            if (req_valid_i) begin
                r_s1_paddr <= req_paddr_i;
                r_s1_tag   <= req_tag_i;
            end
        end
    end

    // S2: take the classified S1 entry when empty or draining.
    // The payload is held otherwise, so the response stays stable under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_valid   <= 1'b0;
            r_s2_tag     <= '0;
            r_s2_cached  <= 1'b0;
            r_s2_exec    <= 1'b0;
            r_s2_nonidem <= 1'b0;
        end else if (flush_i) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_can_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_tag     <= r_s1_tag;
                r_s2_cached  <= w_cached_hit;
                r_s2_exec    <= w_exec_hit;
                r_s2_nonidem <= w_nonidem_hit;
            end
        end
    end

    // Count delivered responses that hit neither a cached nor an execute region.
    // The count saturates, and flush does not clear it.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_unmapped_cnt <= '0;
        else if (w_unmapped_fire && (r_unmapped_cnt != 16'hFFFF))
            r_unmapped_cnt <= r_unmapped_cnt + 16'd1;
    end

    assign rsp_valid_o    = r_s2_valid;
    assign rsp_tag_o      = r_s2_tag;
    assign rsp_cached_o   = r_s2_cached;
    assign rsp_exec_o     = r_s2_exec;
    assign rsp_nonidem_o  = r_s2_nonidem;
    assign unmapped_cnt_o = r_unmapped_cnt;

endmodule

// File: tb/tb_pma_region_classifier.sv
// tb_pma_region_classifier
// Reference model: a queue of in-flight requests, each with flags computed from the memory map.
// A per-cycle monitor compares the DUT against that queue. Directed tests pin literal values.
module tb_pma_region_classifier;
    localparam int PLEN  = 56;
    localparam int TAG_W = 4;

    logic             clk_i       = 1'b0;
    logic             rst_i       = 1'b1;
    logic             flush_i     = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic [PLEN-1:0]  req_paddr_i = '0;
    logic [TAG_W-1:0] req_tag_i   = '0;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b1;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             rsp_cached_o;
    logic             rsp_exec_o;
    logic             rsp_nonidem_o;
    logic [15:0]      unmapped_cnt_o;

    pma_region_classifier dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_paddr_i    (req_paddr_i),
        .req_tag_i      (req_tag_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_tag_o      (rsp_tag_o),
        .rsp_cached_o   (rsp_cached_o),
        .rsp_exec_o     (rsp_exec_o),
        .rsp_nonidem_o  (rsp_nonidem_o),
        .unmapped_cnt_o (unmapped_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [TAG_W-1:0] tag;
        bit               c;
        bit               x;
        bit               n;
        int               acc;
    } exp_t;

    int          n_err = 0;
    int          n_chk = 0;
    int          cyc   = 0;
    bit          rst_done = 1'b0;
    exp_t        q[$];
    exp_t        e;
    int unsigned m_cnt = 0;
    bit          exp_v;
    logic [TAG_W-1:0] dlv_tag[$];
    int               dlv_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory map as plain intervals [base, base+len).
    function automatic bit in_rgn(longint unsigned a, longint unsigned b, longint unsigned l);
        return (a >= b) && (a < b + l);
    endfunction

    function automatic exp_t classify(logic [PLEN-1:0] pa, logic [TAG_W-1:0] t, int acc);
        exp_t r;
        longint unsigned a = longint'(pa);
        r.tag = t;
        r.c   = in_rgn(a, 64'h8000_0000, 64'h4000_0000);
        r.x   = in_rgn(a, 64'h0, 64'h1000) || in_rgn(a, 64'h1_0000, 64'h1_0000) ||
                in_rgn(a, 64'h8000_0000, 64'h4000_0000);
        r.n   = 1'b0;
        r.acc = acc;
        return r;
    endfunction

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_i) rst_done <= 1'b1;
    end

    // Per-cycle comparison against the model queue; the model is then updated for this cycle's handshakes.
    always @(negedge clk_i) begin
        if (rst_done) begin
            exp_v = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
            check("rsp_valid", 64'(rsp_valid_o), 64'(exp_v));
            check("req_ready", 64'(req_ready_o), 64'(!flush_i && !(q.size() == 2 && !rsp_ready_i)));
            check("unmapped_cnt", 64'(unmapped_cnt_o), 64'(m_cnt));
            if (exp_v) begin
                check("rsp_tag",     64'(rsp_tag_o),     64'(q[0].tag));
                check("rsp_cached",  64'(rsp_cached_o),  64'(q[0].c));
                check("rsp_exec",    64'(rsp_exec_o),    64'(q[0].x));
                check("rsp_nonidem", 64'(rsp_nonidem_o), 64'(q[0].n));
            end
            if (exp_v && rsp_ready_i) begin
                e = q.pop_front();
                dlv_tag.push_back(e.tag);
                dlv_cyc.push_back(cyc);
                if (!e.c && !e.x && m_cnt != 32'hFFFF) m_cnt++;
            end
            if (rst_i) begin
                q.delete();
                m_cnt = 0;
            end else begin
                if (flush_i) q.delete();
                if (req_valid_i && req_ready_o && !flush_i)
                    q.push_back(classify(req_paddr_i, req_tag_i, cyc));
            end
        end
    end

    task automatic send(input logic [PLEN-1:0] a, input logic [TAG_W-1:0] t);
        int k = 0;
        req_valid_i = 1'b1;
        req_paddr_i = a;
        req_tag_i   = t;
        @(negedge clk_i);
        while (!req_ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 50) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: req_ready stuck at 0, tag %0d", t);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic single(input logic [PLEN-1:0] a, input logic [TAG_W-1:0] t,
                          input bit ec, input bit ex, input string name);
        send(a, t);
        @(posedge clk_i);
        @(negedge clk_i);
        check({name, "_valid"},  64'(rsp_valid_o),   64'd1);
        check({name, "_tag"},    64'(rsp_tag_o),     64'(t));
        check({name, "_cached"}, 64'(rsp_cached_o),  64'(ec));
        check({name, "_exec"},   64'(rsp_exec_o),    64'(ex));
        check({name, "_nonid"},  64'(rsp_nonidem_o), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    logic [PLEN-1:0] b2b_addr [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        b2b_addr = '{56'h8000_0000, 56'h1_0000, 56'h0, 56'hC000_0004,
                     56'h1_FFFF, 56'h8ABC_0000, 56'h3000_0000, 56'hFFF};
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_valid",  64'(rsp_valid_o),    64'd0);
        check("rst_tag",    64'(rsp_tag_o),      64'd0);
        check("rst_flags",  64'({rsp_cached_o, rsp_exec_o, rsp_nonidem_o}), 64'd0);
        check("rst_cnt",    64'(unmapped_cnt_o), 64'd0);
        check("rst_ready",  64'(req_ready_o),    64'd1);
        @(posedge clk_i);
        #1;

        single(56'h8000_0000,  4'd3, 1'b1, 1'b1, "dflt");
        single(56'hBFFF_FFFF,  4'd4, 1'b1, 1'b1, "dram_top");
        single(56'hC000_0000,  4'd5, 1'b0, 1'b0, "dram_end");
        check("cnt_after_c0", 64'(unmapped_cnt_o), 64'd1);
        single(56'h1_0000,     4'd6, 1'b0, 1'b1, "rom_base");
        single(56'hFFFF,       4'd7, 1'b0, 1'b0, "rom_below");
        single(56'h0FFF,       4'd8, 1'b0, 1'b1, "debug_top");
        single(56'h7FFF_FFFF,  4'd9, 1'b0, 1'b0, "dram_below");
        single({PLEN{1'b1}},   4'd10, 1'b0, 1'b0, "addr_max");
        check("cnt_after_bnd", 64'(unmapped_cnt_o), 64'd4);

        // Eight back-to-back requests with the consumer always ready.
        dlv_tag.delete();
        dlv_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 1'b1;
            req_paddr_i = b2b_addr[i];
            req_tag_i   = 4'(i);
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("b2b_count", 64'(dlv_tag.size()), 64'd8);
        if (dlv_tag.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("b2b_tag", 64'(dlv_tag[i]), 64'(i));
                check("b2b_cycle", 64'(dlv_cyc[i] - dlv_cyc[0]), 64'(i));
            end
        end
        check("cnt_after_b2b", 64'(unmapped_cnt_o), 64'd6);

        // Backpressure: two requests in flight while the consumer stalls.
        rsp_ready_i = 1'b0;
        dlv_tag.delete();
        send(56'h8000_1000, 4'd9);
        send(56'h2000, 4'd10);
        @(negedge clk_i);
        check("bp_full_ready", 64'(req_ready_o), 64'd0);
        repeat (5) @(negedge clk_i);
        check("bp_none_dlv", 64'(dlv_tag.size()), 64'd0);
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("bp_count", 64'(dlv_tag.size()), 64'd2);
        if (dlv_tag.size() == 2) begin
            check("bp_tag0", 64'(dlv_tag[0]), 64'd9);
            check("bp_tag1", 64'(dlv_tag[1]), 64'd10);
        end
        check("bp_ready_after", 64'(req_ready_o), 64'd1);
        check("cnt_after_bp", 64'(unmapped_cnt_o), 64'd7);

        // Flush with two requests in flight. A request offered during the flush is refused.
        rsp_ready_i = 1'b0;
        send(56'h8000_0000, 4'd1);
        send(56'hC000_0000, 4'd2);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_paddr_i = 56'h0;
        req_tag_i   = 4'd5;
        @(negedge clk_i);
        check("flush_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        dlv_tag.delete();
        @(negedge clk_i);
        check("flush_valid", 64'(rsp_valid_o), 64'd0);
        repeat (4) @(posedge clk_i);
        #1;
        check("flush_no_stale", 64'(dlv_tag.size()), 64'd0);
        check("flush_keeps_cnt", 64'(unmapped_cnt_o), 64'd7);
        single(56'h1_0000, 4'd6, 1'b0, 1'b1, "post_flush");

        // Saturate the unmapped counter.
        req_valid_i = 1'b1;
        req_paddr_i = 56'hC000_0000;
        for (int i = 0; i < 65540; i++) begin
            req_tag_i = 4'(i);
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("cnt_saturated", 64'(unmapped_cnt_o), 64'hFFFF);

        // Reset in the middle of a stream discards everything.
        req_valid_i = 1'b1;
        req_paddr_i = 56'h8000_0040;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("mrst_valid", 64'(rsp_valid_o),    64'd0);
        check("mrst_tag",   64'(rsp_tag_o),      64'd0);
        check("mrst_flags", 64'({rsp_cached_o, rsp_exec_o, rsp_nonidem_o}), 64'd0);
        check("mrst_cnt",   64'(unmapped_cnt_o), 64'd0);
        check("mrst_ready", 64'(req_ready_o),    64'd1);
        @(posedge clk_i);
        #1;
        single(56'hBFFF_FFF0, 4'd12, 1'b1, 1'b1, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
